// File: rtl/serdes_rx.sv
// serdes_rx: 8N1-style serial receiver, one line bit per clk cycle.
// Frame: start(0), d0..d7 LSB first, optional even parity, STOP_BITS stop(1).
// Optional feature: define SERDES_RX_PARITY_EN to expect and check a parity bit.
// Completion pulses (valid / frame_err / parity_err) are registered one edge
// after the last stop bit, so the line can carry the next start bit that same edge.
module serdes_rx #(
   parameter int STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       serial_in,
   output logic [7:0] parallel_out,
   output logic       valid,
   output logic       frame_err,
   output logic       parity_err,
   output logic [7:0] err_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      DATA,
`ifdef SERDES_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      WAIT_IDLE
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  bit_cnt_q;
   logic [0:0]  stop_cnt_q;
   logic [7:0]  shift_q;
   logic        serr_q;        // a low stop bit was seen in this frame
   logic        pend_ok_q;     // frame finished cleanly, publish next edge
   logic        pend_ferr_q;
   logic        valid_q;
   logic        frame_err_q;
   logic [7:0]  pout_q;
   logic [7:0]  err_cnt_q;
   logic        last_stop;
   logic        stop_bad;
   logic        fin_ok;
   logic        fin_ferr;
   logic        pend_err;
`ifdef SERDES_RX_PARITY_EN
   logic        par_q;         // running XOR of d0..d7
   logic        perr_q;        // parity mismatch for this frame
   logic        pend_perr_q;
   logic        parity_err_q;
   logic        fin_perr;
`endif

   assign last_stop = (state_q == STOP) && (stop_cnt_q == 1'(STOP_BITS - 1));
   assign stop_bad  = serr_q | ~serial_in;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (!serial_in) state_d = DATA;
         DATA:      if (bit_cnt_q == 3'd7) begin
`ifdef SERDES_RX_PARITY_EN
                       state_d = PARITY;
`else
                       state_d = STOP;
`endif
                    end
`ifdef SERDES_RX_PARITY_EN
         PARITY:    state_d = STOP;
`endif
         STOP:      if (last_stop) state_d = stop_bad ? WAIT_IDLE : IDLE;
         WAIT_IDLE: if (serial_in) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Frame-completion decode on the last stop bit
   always_comb begin
      fin_ok   = 1'b0;
      fin_ferr = 1'b0;
`ifdef SERDES_RX_PARITY_EN
      fin_perr = 1'b0;
`endif
      if (last_stop) begin
         fin_ferr = stop_bad;
`ifdef SERDES_RX_PARITY_EN
         fin_perr = perr_q;
         fin_ok   = ~stop_bad & ~perr_q;
`else
         fin_ok   = ~stop_bad;
`endif
      end
   end

`ifdef SERDES_RX_PARITY_EN
   assign pend_err = pend_ferr_q | pend_perr_q;
`else
   assign pend_err = pend_ferr_q;
`endif

   // Datapath: bit capture, stop checking, and the delayed result pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt_q   <= 3'd0;
         stop_cnt_q  <= 1'b0;
         shift_q     <= 8'h00;
         serr_q      <= 1'b0;
         pend_ok_q   <= 1'b0;
         pend_ferr_q <= 1'b0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         pout_q      <= 8'h00;
         err_cnt_q   <= 8'h00;
      end else begin
         pend_ok_q   <= fin_ok;
         pend_ferr_q <= fin_ferr;
         valid_q     <= pend_ok_q;
         frame_err_q <= pend_ferr_q;
         if (pend_ok_q) pout_q <= shift_q;
         if (pend_err && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
         case (state_q)
            IDLE: if (!serial_in) begin
               bit_cnt_q  <= 3'd0;
               stop_cnt_q <= 1'b0;
               serr_q     <= 1'b0;
            end
            DATA: begin
               shift_q[bit_cnt_q] <= serial_in;
               bit_cnt_q          <= bit_cnt_q + 3'd1;
               stop_cnt_q         <= 1'b0;
            end
            STOP: begin
               if (!serial_in) serr_q <= 1'b1;
               stop_cnt_q <= stop_cnt_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef SERDES_RX_PARITY_EN
   // Parity tracking and its result pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_q        <= 1'b0;
         perr_q       <= 1'b0;
         pend_perr_q  <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         pend_perr_q  <= fin_perr;
         parity_err_q <= pend_perr_q;
         if (state_q == IDLE && !serial_in) begin
            par_q  <= 1'b0;
            perr_q <= 1'b0;
         end
         if (state_q == DATA)   par_q  <= par_q ^ serial_in;
         if (state_q == PARITY) perr_q <= par_q ^ serial_in;
      end
   end
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   assign parallel_out = pout_q;
   assign valid        = valid_q;
   assign frame_err    = frame_err_q;
   assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_serdes_rx.sv
// tb_serdes_rx: table-driven and randomized checks of serdes_rx against a
// line-level model that parses the serial stream into frames.
module tb_serdes_rx;
   localparam int SB = 1;
`ifdef SERDES_RX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int FLEN = 1 + 8 + P + SB;
   localparam int MAXN = 8192;

   logic       clk = 1'b0;
   logic       rst;
   logic       serial_in;
   logic [7:0] parallel_out;
   logic       valid;
   logic       frame_err;
   logic       parity_err;
   logic [7:0] err_cnt;

   serdes_rx #(.STOP_BITS(SB)) dut (
      .clk(clk), .rst(rst), .serial_in(serial_in), .parallel_out(parallel_out),
      .valid(valid), .frame_err(frame_err), .parity_err(parity_err), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;

   bit         line[$];
   bit         ev_on[MAXN];
   logic [7:0] ev_d[MAXN];
   bit         ev_fe[MAXN];
   bit         ev_pe[MAXN];
   logic [7:0] m_data;
   int         m_cnt;
   int         nv, nfe, npe;
   int         vcyc[$];

   typedef struct {
      logic [7:0] data;
      bit         stop_bad;
      int         gap;
      int         exp_v;
      int         exp_fe;
      logic [7:0] exp_out;
      int         exp_cnt;
   } vec_t;
   vec_t tbl[7];

   task automatic chk(input string nm, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic add_bits(input bit b, input int n);
      for (int i = 0; i < n; i++) line.push_back(b);
   endtask

   task automatic add_frame(input logic [7:0] d, input bit stop_bad, input bit par_bad);
      line.push_back(1'b0);
      for (int b = 0; b < 8; b++) line.push_back(d[b]);
      if (P == 1) line.push_back((^d) ^ par_bad);
      for (int s = 0; s < SB; s++) line.push_back(!(stop_bad && s == 0));
   endtask

   // Parse the queued line into frames by the framing rules, then drive it
   // and compare every cycle against the scheduled results.
   task automatic run_line(input string nm);
      int n, i, last, j;
      logic [7:0] d;
      bit fe, pe, ev, ef, ep;
      add_bits(1'b1, 16);
      n = line.size();
      for (int k = 0; k < n; k++) ev_on[k] = 1'b0;
      i = 0;
      while (i < n) begin
         if (line[i]) i++;
         else begin
            last = i + 8 + P + SB;
            if (last + 1 >= n) break;
            for (int b = 0; b < 8; b++) d[b] = line[i + 1 + b];
            pe = (P == 1) ? ((^d) ^ line[i + 9]) : 1'b0;
            fe = 1'b0;
            for (int s = 0; s < SB; s++) if (!line[i + 9 + P + s]) fe = 1'b1;
            ev_on[last + 1] = 1'b1;
            ev_d[last + 1]  = d;
            ev_fe[last + 1] = fe;
            ev_pe[last + 1] = pe;
            if (fe) begin
               j = last + 1;
               while (j < n && !line[j]) j++;
               i = j + 1;
            end else i = last + 1;
         end
      end
      nv = 0; nfe = 0; npe = 0;
      vcyc.delete();
      for (int k = 0; k < n; k++) begin
         serial_in = line[k];
         @(posedge clk);
         #1;
         ev = 1'b0; ef = 1'b0; ep = 1'b0;
         if (ev_on[k]) begin
            ef = ev_fe[k];
            ep = ev_pe[k];
            ev = !ef && !ep;
            if (ev) m_data = ev_d[k];
            else if (m_cnt < 255) m_cnt++;
         end
         chk($sformatf("%s.valid[%0d]", nm, k), int'(valid), int'(ev));
         chk($sformatf("%s.frame_err[%0d]", nm, k), int'(frame_err), int'(ef));
         chk($sformatf("%s.parity_err[%0d]", nm, k), int'(parity_err), int'(ep));
         chk($sformatf("%s.parallel_out[%0d]", nm, k), int'(parallel_out), int'(m_data));
         chk($sformatf("%s.err_cnt[%0d]", nm, k), int'(err_cnt), m_cnt);
         if (valid) begin nv++; vcyc.push_back(k); end
         if (frame_err) nfe++;
         if (parity_err) npe++;
      end
      line.delete();
   endtask

   initial begin
      logic [7:0] prev;
      int         cnt0;
      bit         sb, pb;
      rst = 1'b1;
      serial_in = 1'b1;
      m_data = 8'h00;
      m_cnt = 0;
      #2;
      chk("rst.parallel_out", int'(parallel_out), 0);
      chk("rst.valid", int'(valid), 0);
      chk("rst.frame_err", int'(frame_err), 0);
      chk("rst.parity_err", int'(parity_err), 0);
      chk("rst.err_cnt", int'(err_cnt), 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // data, stop_bad, leading idle, valid pulses, frame_err pulses, out, err_cnt
      tbl[0] = '{8'hA5, 1'b0, 1, 1, 0, 8'hA5, 0};
      tbl[1] = '{8'h3C, 1'b0, 0, 1, 0, 8'h3C, 0};
      tbl[2] = '{8'h55, 1'b1, 2, 0, 1, 8'h3C, 1};
      tbl[3] = '{8'h00, 1'b0, 1, 1, 0, 8'h00, 1};
      tbl[4] = '{8'hFF, 1'b0, 3, 1, 0, 8'hFF, 1};
      tbl[5] = '{8'h80, 1'b1, 1, 0, 1, 8'hFF, 2};
      tbl[6] = '{8'h01, 1'b0, 0, 1, 0, 8'h01, 2};
      for (int t = 0; t < 7; t++) begin
         add_bits(1'b1, tbl[t].gap);
         add_frame(tbl[t].data, tbl[t].stop_bad, 1'b0);
         run_line($sformatf("tbl%0d", t));
         chk($sformatf("tbl%0d.nvalid", t), nv, tbl[t].exp_v);
         chk($sformatf("tbl%0d.nframe_err", t), nfe, tbl[t].exp_fe);
         chk($sformatf("tbl%0d.out", t), int'(parallel_out), int'(tbl[t].exp_out));
         chk($sformatf("tbl%0d.cnt", t), int'(err_cnt), tbl[t].exp_cnt);
      end

      // back-to-back frames with no idle gap
      add_bits(1'b1, 2);
      add_frame(8'h3C, 1'b0, 1'b0);
      add_frame(8'hC3, 1'b0, 1'b0);
      run_line("b2b");
      chk("b2b.nvalid", nv, 2);
      if (vcyc.size() == 2) chk("b2b.spacing", vcyc[1] - vcyc[0], FLEN);
      chk("b2b.out", int'(parallel_out), 8'hC3);

      // bad stop bit followed by a held-low break
      prev = m_data;
      cnt0 = m_cnt;
      add_bits(1'b1, 2);
      add_frame(8'h55, 1'b1, 1'b0);
      add_bits(1'b0, 20);
      add_bits(1'b1, 2);
      run_line("brk");
      chk("brk.nframe_err", nfe, 1);
      chk("brk.nvalid", nv, 0);
      chk("brk.cnt", int'(err_cnt), cnt0 + 1);
      chk("brk.out", int'(parallel_out), int'(prev));
      add_frame(8'h96, 1'b0, 1'b0);
      run_line("brk_after");
      chk("brk_after.out", int'(parallel_out), 8'h96);

      // randomized frame stream
      for (int f = 0; f < 40; f++) begin
         sb = ($urandom_range(0, 5) == 0);
         pb = ($urandom_range(0, 5) == 0);
         add_bits(1'b1, $urandom_range(0, 2));
         add_frame(8'($urandom), sb, pb);
         if (sb) add_bits(1'b0, $urandom_range(0, 4));
      end
      run_line("rnd");

      // reset in the middle of frame 0xFF, after d3
      serial_in = 1'b0;
      @(posedge clk); #1;
      for (int b = 0; b < 4; b++) begin
         serial_in = 1'b1;
         @(posedge clk); #1;
         chk("abort.valid", int'(valid), 0);
         chk("abort.frame_err", int'(frame_err), 0);
      end
      rst = 1'b1;
      #1;
      chk("abort.rst_out", int'(parallel_out), 0);
      chk("abort.rst_cnt", int'(err_cnt), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      m_data = 8'h00;
      m_cnt = 0;
      add_bits(1'b1, 1);
      add_frame(8'h12, 1'b0, 1'b0);
      run_line("abort");
      chk("abort.nvalid", nv, 1);
      chk("abort.nerr", nfe + npe, 0);
      chk("abort.out", int'(parallel_out), 8'h12);

`ifdef SERDES_RX_PARITY_EN
      cnt0 = m_cnt;
      add_bits(1'b1, 1);
      add_frame(8'h01, 1'b0, 1'b1);
      run_line("par_bad");
      chk("par_bad.npe", npe, 1);
      chk("par_bad.nvalid", nv, 0);
      chk("par_bad.cnt", int'(err_cnt), cnt0 + 1);
      add_frame(8'h01, 1'b0, 1'b0);
      run_line("par_ok");
      chk("par_ok.nvalid", nv, 1);
      chk("par_ok.out", int'(parallel_out), 8'h01);
      add_frame(8'h07, 1'b1, 1'b1);
      add_bits(1'b1, 1);
      run_line("par_both");
      chk("par_both.npe", npe, 1);
      chk("par_both.nfe", nfe, 1);
      chk("par_both.cnt", int'(err_cnt), cnt0 + 2);
`endif

      // saturation of the error counter
      for (int f = 0; f < 300; f++) begin
         add_frame(8'(f), 1'b1, 1'b0);
         add_bits(1'b1, 1);
      end
      run_line("sat");
      chk("sat.cnt", int'(err_cnt), 255);
      add_frame(8'hAA, 1'b1, 1'b0);
      run_line("sat_hold");
      chk("sat_hold.cnt", int'(err_cnt), 255);
      chk("sat_hold.nfe", nfe, 1);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
